// File: rtl/ball_motion_pkg.sv
// Shared types and playfield defaults for the ball physics block.
package ball_motion_pkg;

    localparam int POSITION_WIDTH = 16;

    typedef logic [POSITION_WIDTH-1:0] pos_t;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_RUN,
        ST_MISS
    } state_t;

    localparam pos_t DEF_X_MIN = 16'd50;
    localparam pos_t DEF_X_MAX = 16'd1230;
    localparam pos_t DEF_Y_MIN = 16'd50;
    localparam pos_t DEF_Y_MAX = 16'd750;

endpackage

// File: rtl/ball_motion_if.sv
// Frame inputs and ball state outputs shared between the ball block and its neighbours.
interface ball_motion_if;
    import ball_motion_pkg::*;

    logic       vertical_sync;
    logic       serve;
    pos_t       paddle_x;
    pos_t       paddle_y;
    pos_t       ball_x;
    pos_t       ball_y;
    logic       ball_moving;
    logic       miss_pulse;
    logic [7:0] miss_count;

    modport master (
        output vertical_sync, serve, paddle_x, paddle_y,
        input  ball_x, ball_y, ball_moving, miss_pulse, miss_count
    );

    modport slave (
        input  vertical_sync, serve, paddle_x, paddle_y,
        output ball_x, ball_y, ball_moving, miss_pulse, miss_count
    );

endinterface

// File: rtl/ball_motion_axis_step.sv
// One-axis step with clamping bounce at the low and high limits.
module ball_motion_axis_step
    import ball_motion_pkg::*;
(
    input  pos_t pos,
    input  logic dir_neg,
    input  pos_t speed,
    input  pos_t lo,
    input  pos_t hi,
    output pos_t next_pos,
    output logic next_dir_neg,
    output logic hit_lo,
    output logic hit_hi
);

    // Limits are tested as pos vs bound+speed so nothing ever wraps below zero.
    always_comb begin
        next_pos     = pos;
        next_dir_neg = dir_neg;
        hit_lo       = 1'b0;
        hit_hi       = 1'b0;
        if (dir_neg) begin
            if (pos <= lo + speed) begin
                next_pos     = lo;
                next_dir_neg = 1'b0;
                hit_lo       = 1'b1;
            end else begin
                next_pos = pos - speed;
            end
        end else begin
            if (pos + speed >= hi) begin
                next_pos     = hi;
                next_dir_neg = 1'b1;
                hit_hi       = 1'b1;
            end else begin
                next_pos = pos + speed;
            end
        end
    end

endmodule

// File: rtl/ball_motion.sv
// Per-frame ball physics: frame tick, WAIT/RUN/MISS sequencing, paddle and wall bounces, miss counting.
module ball_motion
    import ball_motion_pkg::*;
#(
    parameter pos_t        BALL_RADIUS   = 16'd10,
    parameter pos_t        BALL_SPEED_X  = 16'd4,
    parameter pos_t        BALL_SPEED_Y  = 16'd3,
    parameter pos_t        START_X       = 16'd640,
    parameter pos_t        START_Y       = 16'd400,
    parameter logic        SERVE_DX_NEG  = 1'b0,
    parameter logic        SERVE_DY_NEG  = 1'b0,
    parameter pos_t        X_MIN         = DEF_X_MIN,
    parameter pos_t        X_MAX         = DEF_X_MAX,
    parameter pos_t        Y_MIN         = DEF_Y_MIN,
    parameter pos_t        Y_MAX         = DEF_Y_MAX,
    parameter pos_t        PADDLE_WIDTH  = 16'd20,
    parameter pos_t        PADDLE_LENGTH = 16'd200,
    parameter int unsigned MISS_FRAMES   = 60,
    parameter logic        VSYNC_ACTIVE  = 1'b0
) (
    input  logic pixel_clock,
    input  logic reset_n,
    ball_motion_if.slave bus
);

    // One below the wall so the shared low-limit test becomes the strict miss test.
    localparam pos_t X_LO_MISS = X_MIN + BALL_RADIUS - 16'd1;
    localparam pos_t X_LO      = X_MIN + BALL_RADIUS;
    localparam pos_t X_HI      = X_MAX - BALL_RADIUS;
    localparam pos_t Y_LO      = Y_MIN + BALL_RADIUS;
    localparam pos_t Y_HI      = Y_MAX - BALL_RADIUS;
    localparam pos_t LAST_FRAME = pos_t'(MISS_FRAMES - 1);

    state_t     state, state_n;
    pos_t       x_pos, x_pos_n, y_pos, y_pos_n;
    pos_t       frame_cnt, frame_cnt_n;
    logic       dx_neg, dx_neg_n, dy_neg, dy_neg_n;
    logic [7:0] miss_cnt, miss_cnt_n;
    logic       miss_pulse, miss_pulse_n;
    logic       sync_q, tick;

    pos_t x_step, y_step, paddle_face;
    logic x_dir_step, y_dir_step, x_hit_lo, x_hit_hi, y_hit_lo, y_hit_hi;
    logic paddle_hit;
    logic unused_hits;

    ball_motion_axis_step x_axis (
        .pos          (x_pos),
        .dir_neg      (dx_neg),
        .speed        (BALL_SPEED_X),
        .lo           (X_LO_MISS),
        .hi           (X_HI),
        .next_pos     (x_step),
        .next_dir_neg (x_dir_step),
        .hit_lo       (x_hit_lo),
        .hit_hi       (x_hit_hi)
    );

    ball_motion_axis_step y_axis (
        .pos          (y_pos),
        .dir_neg      (dy_neg),
        .speed        (BALL_SPEED_Y),
        .lo           (Y_LO),
        .hi           (Y_HI),
        .next_pos     (y_step),
        .next_dir_neg (y_dir_step),
        .hit_lo       (y_hit_lo),
        .hit_hi       (y_hit_hi)
    );

    assign unused_hits = ^{x_hit_hi, y_hit_lo, y_hit_hi};

    assign paddle_face = bus.paddle_x + PADDLE_WIDTH + BALL_RADIUS;
    assign paddle_hit  = dx_neg
                      && (x_pos >= paddle_face)
                      && (x_pos <= paddle_face + BALL_SPEED_X)
                      && (bus.paddle_y <= y_pos + BALL_RADIUS)
                      && (y_pos <= bus.paddle_y + PADDLE_LENGTH + BALL_RADIUS);

    always_ff @(posedge pixel_clock) begin
        if (!reset_n) begin
            sync_q     <= ~VSYNC_ACTIVE;
            tick       <= 1'b0;
            state      <= ST_WAIT;
            x_pos      <= START_X;
            y_pos      <= START_Y;
            dx_neg     <= SERVE_DX_NEG;
            dy_neg     <= SERVE_DY_NEG;
            frame_cnt  <= '0;
            miss_cnt   <= '0;
            miss_pulse <= 1'b0;
        end else begin
            sync_q     <= bus.vertical_sync;
            tick       <= (bus.vertical_sync == VSYNC_ACTIVE) && (sync_q != VSYNC_ACTIVE);
            state      <= state_n;
            x_pos      <= x_pos_n;
            y_pos      <= y_pos_n;
            dx_neg     <= dx_neg_n;
            dy_neg     <= dy_neg_n;
            frame_cnt  <= frame_cnt_n;
            miss_cnt   <= miss_cnt_n;
            miss_pulse <= miss_pulse_n;
        end
    end

    always_comb begin
        state_n      = state;
        x_pos_n      = x_pos;
        y_pos_n      = y_pos;
        dx_neg_n     = dx_neg;
        dy_neg_n     = dy_neg;
        frame_cnt_n  = frame_cnt;
        miss_cnt_n   = miss_cnt;
        miss_pulse_n = 1'b0;
        case (state)
            ST_WAIT: begin
                x_pos_n = START_X;
                y_pos_n = START_Y;
                if (tick && bus.serve) begin
                    state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                if (tick) begin
                    y_pos_n  = y_step;
                    dy_neg_n = y_dir_step;
                    if (!dx_neg) begin
                        x_pos_n  = x_step;
                        dx_neg_n = x_dir_step;
                    end else if (paddle_hit) begin
                        x_pos_n  = paddle_face;
                        dx_neg_n = 1'b0;
                    end else if (x_hit_lo) begin
                        x_pos_n      = X_LO;
                        miss_pulse_n = 1'b1;
                        miss_cnt_n   = (miss_cnt == 8'hFF) ? miss_cnt : miss_cnt + 8'd1;
                        frame_cnt_n  = '0;
                        state_n      = ST_MISS;
                    end else begin
                        x_pos_n = x_step;
                    end
                end
            end
            ST_MISS: begin
                if (tick) begin
                    if (frame_cnt == LAST_FRAME) begin
                        x_pos_n     = START_X;
                        y_pos_n     = START_Y;
                        dx_neg_n    = SERVE_DX_NEG;
                        dy_neg_n    = SERVE_DY_NEG;
                        frame_cnt_n = '0;
                        state_n     = ST_WAIT;
                    end else begin
                        frame_cnt_n = frame_cnt + 16'd1;
                    end
                end
            end
            default: state_n = ST_WAIT;
        endcase
    end

    assign bus.ball_x      = x_pos;
    assign bus.ball_y      = y_pos;
    assign bus.ball_moving = (state == ST_RUN);
    assign bus.miss_pulse  = miss_pulse;
    assign bus.miss_count  = miss_cnt;

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench: four ball_motion instances with different serve setups driven by shared frame ticks.
module tb_ball_motion;
    import ball_motion_pkg::*;

    logic pixel_clock;
    logic reset_n;
    int   total;
    int   bad;
    int   pulse_count;

    ball_motion_if ifa ();
    ball_motion_if ifb ();
    ball_motion_if ifc ();
    ball_motion_if ifd ();

    ball_motion dut_a (
        .pixel_clock (pixel_clock),
        .reset_n     (reset_n),
        .bus         (ifa)
    );

    ball_motion #(.START_Y(16'd736)) dut_b (
        .pixel_clock (pixel_clock),
        .reset_n     (reset_n),
        .bus         (ifb)
    );

    ball_motion #(.SERVE_DX_NEG(1'b1), .START_X(16'd148), .START_Y(16'd200)) dut_c (
        .pixel_clock (pixel_clock),
        .reset_n     (reset_n),
        .bus         (ifc)
    );

    ball_motion #(.SERVE_DX_NEG(1'b1), .START_X(16'd66), .START_Y(16'd400)) dut_d (
        .pixel_clock (pixel_clock),
        .reset_n     (reset_n),
        .bus         (ifd)
    );

    initial pixel_clock = 1'b0;
    always #5 pixel_clock = ~pixel_clock;

    always @(negedge pixel_clock) begin
        if (ifd.miss_pulse === 1'b1) pulse_count++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic setFrameInputs(input logic vsync, input logic serve);
        ifa.vertical_sync = vsync;  ifa.serve = serve;
        ifb.vertical_sync = vsync;  ifb.serve = serve;
        ifc.vertical_sync = vsync;  ifc.serve = serve;
        ifd.vertical_sync = vsync;  ifd.serve = serve;
    endtask

    // vsync is active-low: hold it low a few cycles so one tick is produced, then release.
    task automatic applyStimulus(input logic serve);
        @(negedge pixel_clock);
        setFrameInputs(1'b0, serve);
        repeat (3) @(negedge pixel_clock);
        setFrameInputs(1'b1, 1'b0);
        repeat (2) @(negedge pixel_clock);
    endtask

    initial begin
        total = 0;
        bad = 0;
        pulse_count = 0;
        reset_n = 1'b0;
        setFrameInputs(1'b1, 1'b0);
        ifa.paddle_x = 16'd20;   ifa.paddle_y = 16'd100;
        ifb.paddle_x = 16'd20;   ifb.paddle_y = 16'd100;
        ifc.paddle_x = 16'd110;  ifc.paddle_y = 16'd110;
        ifd.paddle_x = 16'd110;  ifd.paddle_y = 16'd500;
        repeat (3) @(negedge pixel_clock);

        checkOutput("reset_x", 32'(ifa.ball_x), 32'd640);
        checkOutput("reset_y", 32'(ifa.ball_y), 32'd400);
        checkOutput("reset_moving", 32'(ifa.ball_moving), 32'd0);
        checkOutput("reset_pulse", 32'(ifa.miss_pulse), 32'd0);
        checkOutput("reset_count", 32'(ifa.miss_count), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0);
            checkOutput("park_x", 32'(ifa.ball_x), 32'd640);
            checkOutput("park_y", 32'(ifa.ball_y), 32'd400);
            checkOutput("park_moving", 32'(ifa.ball_moving), 32'd0);
            checkOutput("park_count", 32'(ifa.miss_count), 32'd0);
        end

        applyStimulus(1'b1);
        checkOutput("serve_x", 32'(ifa.ball_x), 32'd640);
        checkOutput("serve_y", 32'(ifa.ball_y), 32'd400);
        checkOutput("serve_moving", 32'(ifa.ball_moving), 32'd1);
        checkOutput("serve_d_moving", 32'(ifd.ball_moving), 32'd1);

        for (int t = 1; t <= 63; t++) begin
            applyStimulus(1'b0);
            case (t)
                1: begin
                    checkOutput("a_t1_x", 32'(ifa.ball_x), 32'd644);
                    checkOutput("a_t1_y", 32'(ifa.ball_y), 32'd403);
                    checkOutput("b_t1_y", 32'(ifb.ball_y), 32'd739);
                    checkOutput("c_t1_x", 32'(ifc.ball_x), 32'd144);
                    checkOutput("d_t1_x", 32'(ifd.ball_x), 32'd62);
                    checkOutput("d_t1_pulses", 32'(pulse_count), 32'd0);
                end
                2: begin
                    checkOutput("b_clamp_y", 32'(ifb.ball_y), 32'd740);
                    checkOutput("c_face_x", 32'(ifc.ball_x), 32'd140);
                    checkOutput("d_miss_x", 32'(ifd.ball_x), 32'd60);
                    checkOutput("d_miss_pulses", 32'(pulse_count), 32'd1);
                    checkOutput("d_miss_count", 32'(ifd.miss_count), 32'd1);
                    checkOutput("d_miss_moving", 32'(ifd.ball_moving), 32'd0);
                end
                3: begin
                    checkOutput("b_up_y", 32'(ifb.ball_y), 32'd737);
                    checkOutput("c_rebound_x", 32'(ifc.ball_x), 32'd144);
                    checkOutput("d_frozen_x", 32'(ifd.ball_x), 32'd60);
                    checkOutput("d_frozen_y", 32'(ifd.ball_y), 32'd406);
                    checkOutput("d_t3_pulses", 32'(pulse_count), 32'd1);
                end
                6: begin
                    checkOutput("a_t6_x", 32'(ifa.ball_x), 32'd664);
                    checkOutput("a_t6_y", 32'(ifa.ball_y), 32'd418);
                end
                61: begin
                    checkOutput("d_t61_x", 32'(ifd.ball_x), 32'd60);
                    checkOutput("d_t61_y", 32'(ifd.ball_y), 32'd406);
                    checkOutput("d_t61_moving", 32'(ifd.ball_moving), 32'd0);
                end
                62: begin
                    checkOutput("d_home_x", 32'(ifd.ball_x), 32'd66);
                    checkOutput("d_home_y", 32'(ifd.ball_y), 32'd400);
                    checkOutput("d_home_moving", 32'(ifd.ball_moving), 32'd0);
                end
                63: begin
                    checkOutput("d_wait_x", 32'(ifd.ball_x), 32'd66);
                    checkOutput("d_wait_count", 32'(ifd.miss_count), 32'd1);
                    checkOutput("a_still_moving", 32'(ifa.ball_moving), 32'd1);
                end
                default: ;
            endcase
        end

        // Reset lands on the same edge the pending tick would act on.
        @(negedge pixel_clock);
        setFrameInputs(1'b0, 1'b0);
        @(negedge pixel_clock);
        reset_n = 1'b0;
        @(negedge pixel_clock);
        checkOutput("rst_x", 32'(ifa.ball_x), 32'd640);
        checkOutput("rst_y", 32'(ifa.ball_y), 32'd400);
        checkOutput("rst_moving", 32'(ifa.ball_moving), 32'd0);
        checkOutput("rst_d_count", 32'(ifd.miss_count), 32'd0);
        checkOutput("rst_d_x", 32'(ifd.ball_x), 32'd66);
        reset_n = 1'b1;
        setFrameInputs(1'b1, 1'b0);
        repeat (3) @(negedge pixel_clock);
        checkOutput("rst_nostep_x", 32'(ifa.ball_x), 32'd640);
        applyStimulus(1'b0);
        checkOutput("rst_wait_y", 32'(ifa.ball_y), 32'd400);
        checkOutput("rst_wait_moving", 32'(ifa.ball_moving), 32'd0);
        checkOutput("rst_pulses", 32'(pulse_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
